// File: rtl/lsu_controller.sv
// Load/store sequencer: turns a datapath load/store into one handshaked word access
// with byte lanes, then returns extended load data or an error code as a one-cycle response.
module lsu_controller #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  err,
   output logic        bus_cs,
   output logic        bus_rd_en,
   output logic        bus_wr_en,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_mask,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       acc_func3;
   logic [1:0]       acc_off;
   logic             acc_store;

   logic [1:0]  off;
   logic        illegal;
   logic        misaligned;
   logic [3:0]  lane_mask;
   logic [31:0] store_data;
   logic [31:0] shifted;
   logic [31:0] load_data;

   assign off   = addr[1:0];
   assign stall = mem_req & (state != RESP) & ~rst;

   // Request decode: legality, alignment and lane placement of the incoming access
   always_comb begin
      illegal    = mem_we ? (func3 >= 3'b011) : ((func3 == 3'b011) || (func3[2:1] == 2'b11));
      misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                   ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      case (func3[1:0])
         2'b00: begin
            lane_mask  = 4'b0001 << off;
            store_data = {4{wdata[7:0]}};
         end
         2'b01: begin
            lane_mask  = 4'b0011 << off;
            store_data = {2{wdata[15:0]}};
         end
         default: begin
            lane_mask  = 4'b1111;
            store_data = wdata;
         end
      endcase
   end

   // Load extraction uses the size/offset captured when the access started
   always_comb begin
      shifted = bus_rdata >> {acc_off, 3'b000};
      case (acc_func3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc_func3 <= 3'b000;
         acc_off   <= 2'b00;
         acc_store <= 1'b0;
         done      <= 1'b0;
         rdata     <= 32'd0;
         err       <= 2'b00;
         bus_cs    <= 1'b1;
         bus_rd_en <= 1'b0;
         bus_wr_en <= 1'b1;
         bus_addr  <= 32'd0;
         bus_mask  <= 4'd0;
         bus_wdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  if (illegal) begin
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 2'b11;
                     rdata <= 32'd0;
                  end else if (misaligned) begin
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 2'b01;
                     rdata <= 32'd0;
                  end else begin
                     state     <= ACCESS;
                     cnt       <= '0;
                     acc_func3 <= func3;
                     acc_off   <= off;
                     acc_store <= mem_we;
                     bus_cs    <= 1'b0;
                     bus_rd_en <= ~mem_we;
                     bus_wr_en <= ~mem_we;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_mask  <= lane_mask;
                     bus_wdata <= mem_we ? store_data : 32'd0;
                  end
               end
            end
            ACCESS: begin
               // Ack is checked first so a last-cycle ack still completes normally
               if (bus_ack || (cnt == CNT_LAST)) begin
                  state     <= RESP;
                  done      <= 1'b1;
                  bus_cs    <= 1'b1;
                  bus_rd_en <= 1'b0;
                  bus_wr_en <= 1'b1;
                  bus_addr  <= 32'd0;
                  bus_mask  <= 4'd0;
                  bus_wdata <= 32'd0;
                  if (bus_ack) begin
                     err <= 2'b00;
                     if (!acc_store) rdata <= load_data;
                  end else begin
                     err   <= 2'b10;
                     rdata <= 32'd0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Multi-cycle load/store sequencer between the core datapath and a handshaked data-memory bus. When decode flags a load or store, the block stalls the PC. It converts the RV32I size code (func3) and low address bits into a word-aligned bus access with byte mask. It waits for the memory ack, then returns aligned, sign/zero-extended load data. Misaligned, illegal-size and timed-out accesses finish as a single-cycle error response instead of hanging the core.

## Interface
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without ack before abort; must be ≥1
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_req  in  1  datapath has a load/store in flight; held until done
- mem_we  in  1  1 = store, 0 = load; valid with mem_req
- func3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/IR this cycle
- done  out  1  one-cycle pulse; rdata/err valid
- rdata  out  32  aligned, extended load data
- err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal func3
- bus_cs  out  1  chip select, active-low
- bus_rd_en  out  1  read strobe, active-high
- bus_wr_en  out  1  write enable, active-low
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_mask  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data; valid with bus_ack
- bus_ack  in  1  access complete; sampled only in ACCESS

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, mem_req=1, legal and aligned: latch bus outputs and go to ACCESS; clear the timeout counter.
- IDLE, mem_req=1, illegal func3: go to RESP with err=11. No bus activity.
- IDLE, mem_req=1, legal but misaligned: go to RESP with err=01. No bus activity. Misaligned means H with addr[0]=1, or W with addr[1:0]≠0.
- Illegal func3: 011, 110, 111 for loads; any value ≥011 for stores. Illegal takes priority over misaligned.
- ACCESS, bus_ack=1: go to RESP. Loads register the extracted data. err=00.
- ACCESS, no ack, counter = TIMEOUT_CYCLES-1: go to RESP with err=10 and rdata=0. Otherwise increment the counter.
- RESP: done=1; next state is IDLE unconditionally.
- Lane selection, off = addr[1:0]:
  - B: mask = 0001<<off
  - H: mask = 0011<<off
  - W: mask = 1111
- Store data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Loads drive the same mask and bus_wdata = 0.
- Load extract: byte/half = bus_rdata >> (8·off). LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Bus control is registered:
  - In ACCESS: bus_cs=0. Loads: bus_rd_en=1, bus_wr_en=1. Stores: bus_rd_en=0, bus_wr_en=0.
  - Outside ACCESS: bus_cs=1, bus_rd_en=0, bus_wr_en=1, and addr/mask/wdata return to 0.
- stall = mem_req & (state≠RESP) & ~rst. It is combinational, so the PC holds in the same cycle the request appears.
- err and rdata hold their values until the next RESP overwrites them. done is high only in RESP.

## Timing
- Reset values: state IDLE, stall 0, done 0, rdata 0, err 00, bus_cs 1, bus_rd_en 0, bus_wr_en 1, bus_addr 0, bus_mask 0, bus_wdata 0, counter 0.
- Reset mid-access returns everything to the reset values immediately. The transaction is abandoned and not replayed.
- Zero-wait bus:
  - cycle 0 IDLE (stall=1)
  - cycle 1 ACCESS (cs low, ack high)
  - cycle 2 RESP (done=1, stall=0)
  - Total latency 3 cycles; N wait cycles add N.
- Error without bus access: cycle 0 IDLE, cycle 1 RESP. Latency 2.
- Timeout: RESP occurs TIMEOUT_CYCLES+1 cycles after the request is accepted.
- If ack arrives in the same cycle the counter hits its limit, ack wins and err=00.
- Ack in IDLE or RESP is ignored. Bus inputs are not sampled outside ACCESS.
- A new mem_req in the cycle after RESP is a new access. Back-to-back accesses therefore cost 3 cycles each.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Reset mid-ACCESS: assert rst while bus_cs=0 → bus_cs=1 at once and state IDLE. After rst falls, a later ack alone produces no done.
- LB at addr 0x103, bus_rdata 0x80_11_22_33, zero-wait → mask 1000, bus_addr 0x100. done at cycle 2 with rdata 0xFFFFFF80. With func3=100 (LBU), rdata 0x00000080.
- SH at addr 0x202, wdata 0x1234ABCD, ack after 3 waits → bus_wr_en=0, mask 1100, bus_wdata 0xABCDABCD. cs low 4 cycles; done at cycle 5 with err 00.
- LW at addr 0x0006 → no cs assertion; done at cycle 1 with err 01. LH func3=011 → err 11.
- TIMEOUT_CYCLES=4, no ack → cs low exactly 4 cycles, then done with err 10 and rdata 0. Repeat with ack on the 4th ACCESS cycle → err 00.
- Two back-to-back LW with zero-wait → done pulses 3 cycles apart. stall is low only in the RESP cycles.
